// File: rtl/iter_alu.sv
// Registered MIPS-style ALU with a start/busy/done handshake and an iterative shift-add MULTU.
// Define ITER_ALU_DIVU_EN to add a restoring unsigned divide (op 10) in its own DIV state.
module iter_alu #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic [N-1:0] out,
  output logic         zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd12;
`ifdef ITER_ALU_DIVU_EN
  localparam logic [3:0] OP_DIVU  = 4'd10;
`endif
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

`ifdef ITER_ALU_DIVU_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic          done_q, done_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic          last_iter;
  logic [N:0]    mul_sum;

  function automatic logic [N-1:0] alu_single(input logic [3:0] f,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    case (f)
      OP_AND:  alu_single = a & b;
      OP_OR:   alu_single = a | b;
      OP_ADD:  alu_single = a + b;
      OP_SUB:  alu_single = a - b;
      OP_SLT:  alu_single = {{(N-1){1'b0}}, (a < b)};
      OP_NOR:  alu_single = ~(a | b);
      default: alu_single = '0;
    endcase
  endfunction

  assign last_iter = (cnt_q == LAST_ITER);
  assign mul_sum   = {1'b0, hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});

`ifdef ITER_ALU_DIVU_EN
  logic [N:0]   div_trial;
  logic         div_ge;
  logic [N-1:0] div_rem;
  // A zero divisor always compares >=, which yields quotient all ones and remainder = dividend.
  assign div_trial = {hi_q, lo_q[N-1]};
  assign div_ge    = (div_trial >= {1'b0, mcand_q});
  assign div_rem   = div_trial[N-1:0] - mcand_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FIN dispatches like IDLE so a start in the done cycle is never lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          if (op == OP_MULTU) state_d = S_MUL;
`ifdef ITER_ALU_DIVU_EN
          else if (op == OP_DIVU) state_d = S_DIV;
`endif
        end
      end
      S_MUL: if (last_iter) state_d = S_FIN;
`ifdef ITER_ALU_DIVU_EN
      S_DIV: if (last_iter) state_d = S_FIN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_MUL: busy = 1'b1;
`ifdef ITER_ALU_DIVU_EN
      S_DIV: busy = 1'b1;
`endif
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          cnt_d = '0;
          if (op == OP_MULTU) begin
            mcand_d  = inA;
            mplier_d = inB;
            hi_d     = '0;
            lo_d     = '0;
          end
`ifdef ITER_ALU_DIVU_EN
          else if (op == OP_DIVU) begin
            mcand_d = inB;
            hi_d    = '0;
            lo_d    = inA;
          end
`endif
          else begin
            out_d  = alu_single(op, inA, inB);
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        hi_d     = mul_sum[N:1];
        lo_d     = {mul_sum[0], lo_q[N-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          out_d  = lo_d;
          done_d = 1'b1;
        end
      end
`ifdef ITER_ALU_DIVU_EN
      S_DIV: begin
        hi_d  = div_ge ? div_rem : div_trial[N-1:0];
        lo_d  = {lo_q[N-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          out_d  = lo_d;
          done_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      out_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  // Operand latches are data only; they are always loaded before use.
  always_ff @(posedge clock) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign out  = out_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign zero = (out_q == '0);

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases followed by randomized operations
// compared against an arithmetic reference model.
module tb_iter_alu;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] inA, inB;
  logic [N-1:0] out, hi, lo;
  logic         zero, busy, done;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] m_hi, m_lo;

  iter_alu #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .out(out), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: results from plain arithmetic; hi/lo only change on MULTU/DIVU.
  task automatic ref_op(input logic [3:0] f, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] r, output bit iter);
    longint unsigned ua, ub, p;
    ua = longint'(a);
    ub = longint'(b);
    iter = 1'b0;
    r = '0;
    case (f)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = N'(ua + ub);
      4'd6:  r = N'(ua - ub);
      4'd7:  r = (ua < ub) ? N'(1) : N'(0);
      4'd12: r = ~(a | b);
      4'd8: begin
        p = ua * ub;
        m_hi = N'(p >> N);
        m_lo = N'(p);
        r = m_lo;
        iter = 1'b1;
      end
`ifdef ITER_ALU_DIVU_EN
      4'd10: begin
        if (ub == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = N'(ua / ub);
          m_hi = N'(ua % ub);
        end
        r = m_lo;
        iter = 1'b1;
      end
`endif
      default: r = '0;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic [N-1:0] a,
                        input logic [N-1:0] b, input bit noisy);
    logic [N-1:0] r;
    bit it;
    int cyc, bcnt;
    ref_op(f, a, b, r, it);
    start = 1'b1; op = f; inA = a; inB = b;
    tick();
    start = 1'b0;
    if (it) begin
      cyc = 1;
      bcnt = 0;
      while (!done && cyc < 4 * N) begin
        if (busy) bcnt++;
        if (noisy) begin
          start = 1'($urandom_range(0, 1));
          op    = 4'($urandom);
          inA   = N'($urandom);
          inB   = N'($urandom);
        end
        tick();
        cyc++;
      end
      start = 1'b0;
      check({tag, " latency"}, 32'(cyc), 32'(N + 1));
      check({tag, " busy_cycles"}, 32'(bcnt), 32'(N));
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " out"}, 32'(out), 32'(r));
    check({tag, " zero"}, 32'(zero), 32'(r == '0));
    check({tag, " hi"}, 32'(hi), 32'(m_hi));
    check({tag, " lo"}, 32'(lo), 32'(m_lo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ops [10];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd10, 4'd3, 4'd15};
    reset = 1'b1; start = 1'b0; op = '0; inA = '0; inB = '0;
    m_hi = '0; m_lo = '0;
    #2 reset = 1'b0;
    #1;
    check("rst out", 32'(out), 32'd0);
    check("rst hi", 32'(hi), 32'd0);
    check("rst lo", 32'(lo), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    tick();

    run_op("add", 4'd2, 8'h7F, 8'h01, 1'b0);
    run_op("sub", 4'd6, 8'd5, 8'd5, 1'b0);
    run_op("and", 4'd0, 8'hF0, 8'h3C, 1'b0);
    run_op("or", 4'd1, 8'hF0, 8'h3C, 1'b0);
    run_op("nor", 4'd12, 8'hF0, 8'h3C, 1'b0);
    run_op("slt", 4'd7, 8'd3, 8'd9, 1'b0);
    run_op("slt_ge", 4'd7, 8'd9, 8'd3, 1'b0);
    run_op("mul_ff", 4'd8, 8'hFF, 8'hFF, 1'b1);

    // Abort a multiply mid-way with an asynchronous reset.
    start = 1'b1; op = 4'd8; inA = 8'h12; inB = 8'h34;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("abort out", 32'(out), 32'd0);
    check("abort hi", 32'(hi), 32'd0);
    check("abort lo", 32'(lo), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort zero", 32'(zero), 32'd1);
    m_hi = '0; m_lo = '0;
    @(negedge clock) reset = 1'b1;
    repeat (2) begin
      tick();
      check("abort no_done", 32'(done), 32'd0);
    end
    run_op("mul_12x34", 4'd8, 8'h12, 8'h34, 1'b0);
    run_op("unknown_f", 4'hF, 8'h55, 8'hAA, 1'b0);
    run_op("divu_100_7", 4'd10, 8'd100, 8'd7, 1'b0);
    run_op("divu_by0", 4'd10, 8'd100, 8'd0, 1'b0);
    run_op("add_wrap", 4'd2, 8'hFF, 8'h02, 1'b0);
    run_op("sub_wrap", 4'd6, 8'h00, 8'h01, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 9)], N'($urandom), N'($urandom),
             1'b1);
    end

    tick();
    check("idle done", 32'(done), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
